// File: rtl/axil_addn_fifo_bank.sv
// rtl/axil_addn_fifo_bank.sv - AXI4-Lite bank of per-channel add-N FIFOs with status and sticky errors
// Optional feature macro: AXIL_ADDN_SLVERR_EN (SLVERR on overflow push / underflow pop)
module axil_addn_fifo_bank #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_CH             = 4,
  parameter int          FIFO_DEPTH         = 8,
  parameter logic [31:0] INC_RESET          = 32'd1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            IRQ
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = C_S_AXI_ADDR_WIDTH - 2;

  logic          r_awready, r_wready, r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_arready, r_rvalid;
  logic [1:0]    r_rresp;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_inc;
  logic [DW-1:0] r_err;
  logic          r_irq;
  logic [PW-1:0] r_wptr [NUM_CH];
  logic [PW-1:0] r_rptr [NUM_CH];
  logic [DW-1:0] r_mem  [NUM_CH][FIFO_DEPTH];

  logic              w_wr_en, w_rd_en;
  logic [WW-1:0]     w_wr_word, w_rd_word;
  logic [PW-1:0]     w_cnt [NUM_CH];
  logic [NUM_CH-1:0] w_empty, w_full;
  logic [NUM_CH-1:0] w_push_req, w_pop_req, w_push_ok, w_pop_ok, w_ovf, w_udf;
  logic [DW-1:0]     w_status, w_err_set, w_err_clr, w_byte_mask, w_rd_val, w_push_val;
  logic [1:0]        w_bresp_next, w_rresp_next;
  logic              w_unused;

  assign w_wr_en    = r_awready & r_wready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_en    = r_arready & S_AXI_ARVALID;
  assign w_wr_word  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_rd_word  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  // Pushes use the increment held before this edge; an INC write in the same cycle lands afterwards.
  assign w_push_val = S_AXI_WDATA + r_inc;
  assign w_unused   = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

`ifdef AXIL_ADDN_SLVERR_EN
  assign w_bresp_next = (|w_ovf) ? 2'b10 : 2'b00;
  assign w_rresp_next = (|w_udf) ? 2'b10 : 2'b00;
`else
  assign w_bresp_next = 2'b00;
  assign w_rresp_next = 2'b00;
`endif

  // Expand byte strobes into a bit mask for INC writes and ERR clears.
  always_comb begin
    w_byte_mask = '0;
    for (int b = 0; b < DW / 8; b++) begin
      w_byte_mask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
    end
  end

  // Per-channel occupancy, push/pop qualification and error events.
  always_comb begin
    w_empty    = '0;
    w_full     = '0;
    w_push_req = '0;
    w_pop_req  = '0;
    w_push_ok  = '0;
    w_pop_ok   = '0;
    w_ovf      = '0;
    w_udf      = '0;
    w_status   = '0;
    w_err_set  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cnt[k]      = r_wptr[k] - r_rptr[k];
      w_empty[k]    = (w_cnt[k] == '0);
      w_full[k]     = (w_cnt[k] == PW'(FIFO_DEPTH));
      w_push_req[k] = w_wr_en && (w_wr_word == WW'(k + 4));
      w_pop_req[k]  = w_rd_en && (w_rd_word == WW'(k + 4));
      w_pop_ok[k]   = w_pop_req[k] && !w_empty[k];
      // A simultaneous pop frees the slot, so a full channel still accepts the push.
      w_push_ok[k]  = w_push_req[k] && (!w_full[k] || w_pop_ok[k]);
      w_ovf[k]      = w_push_req[k] && !w_push_ok[k];
      w_udf[k]      = w_pop_req[k] && w_empty[k];
      w_status[k]     = w_empty[k];
      w_status[8 + k] = w_full[k];
      w_err_set[k]     = w_ovf[k];
      w_err_set[8 + k] = w_udf[k];
    end
    w_status[31:16] = 16'(w_cnt[0]);
  end

  assign w_err_clr = (w_wr_en && (w_wr_word == WW'(2))) ? (S_AXI_WDATA & w_byte_mask) : '0;

  // Read data mux, evaluated at the AR accept edge; popping an empty channel returns zero.
  always_comb begin
    w_rd_val = '0;
    if (w_rd_word == WW'(0)) w_rd_val = r_inc;
    if (w_rd_word == WW'(1)) w_rd_val = w_status;
    if (w_rd_word == WW'(2)) w_rd_val = r_err;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_rd_word == WW'(k + 4) && !w_empty[k]) begin
        w_rd_val = r_mem[k][r_rptr[k][AW-1:0]];
      end
    end
  end

  // Write channel: one-cycle AW/W ready pulse, then BVALID held until BREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_awready <= !r_awready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
      r_wready  <= !r_wready  && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_bresp_next;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
        r_bresp  <= 2'b00;
      end
    end
  end

  // Read channel: one-cycle AR ready pulse, registered data held until RREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      r_arready <= !r_arready && S_AXI_ARVALID && !r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
        r_rresp  <= w_rresp_next;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Control registers: INC with byte strobes, sticky ERR where a new event beats a clear, IRQ one cycle behind ERR.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_inc <= INC_RESET;
      r_err <= '0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr_en && (w_wr_word == WW'(0))) begin
        r_inc <= (r_inc & ~w_byte_mask) | (S_AXI_WDATA & w_byte_mask);
      end
      r_err <= (r_err & ~w_err_clr) | w_err_set;
      r_irq <= |r_err;
    end
  end

  // FIFO pointers; the difference wraps naturally with the extra pointer bit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_push_ok[k]) r_wptr[k] <= r_wptr[k] + 1'b1;
        if (w_pop_ok[k])  r_rptr[k] <= r_rptr[k] + 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge ACLK) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_push_ok[k]) r_mem[k][r_wptr[k][AW-1:0]] <= w_push_val;
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign IRQ           = r_irq;

endmodule

// File: doc/axil_addn_fifo_bank.md
Name: axil_addn_fifo_bank

Overview:
AXI4-Lite slave peripheral and the next generation of the single add-one register block. It holds NUM_CH independent channels. A write to a channel data register computes WDATA + INC and pushes the result into that channel's FIFO; a read pops the oldest result. It sits behind the same AXI interconnect or VIP master as the add-one block. It adds a programmable increment, per-channel buffering, status and sticky error reporting.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must cover 0x10 + 4*NUM_CH.
NUM_CH, 4, number of channels, 1..8.
FIFO_DEPTH, 8, entries per channel; power of two, 2..64.
INC_RESET, 1, reset value of the INC register.

Ports:
ACLK  in  1  clock; all logic is rising-edge.
ARESET  in  1  synchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
IRQ  out  1  level; high when any ERR bit is set.

Behaviour:
- Register map (word offsets; ADDR[1:0] ignored):
  - 0x00 INC: RW; WSTRB applied.
  - 0x04 STATUS: RO. Bit k = ch k empty; bit 8+k = ch k full; bits [31:16] = ch0 count.
  - 0x08 ERR: W1C, WSTRB applied. Bit k = ch k overflow; bit 8+k = ch k underflow.
  - 0x0C: reserved; reads 0, writes dropped.
  - 0x10+4k CH_DATA[k]: a write pushes, a read pops. WSTRB is ignored for pushes.
  - Offsets beyond the last channel: read 0, writes dropped, OKAY.
- Reset values: all READY/VALID outputs 0, BRESP/RRESP 00, RDATA 0, IRQ 0, INC = INC_RESET, ERR 0, all FIFOs empty.
- Write channel:
  - AWREADY and WREADY pulse high together for one cycle when AWVALID & WVALID & !BVALID.
  - The register effect happens on that accept edge.
  - BVALID rises the next cycle and holds until BREADY. At most one write is outstanding.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID & !RVALID.
  - RDATA and RVALID are registered the next cycle. RDATA is stable until RREADY.
  - A pop happens on the AR accept edge.
- Push: the stored value is (WDATA + INC) mod 2^32, using INC as it was before this cycle's write. If the channel is full, the value is dropped and ERR overflow[k] is set.
- Pop on an empty channel: RDATA = 0 and ERR underflow[k] is set.
- A pushed value can be popped by an AR accepted one cycle after the push, not in the same cycle.
- Push and pop on the same channel in the same cycle:
  - Non-empty: count is unchanged, even when full (no overflow).
  - Empty: the pop underflows and the push still lands.
- FIFO pointers have log2(FIFO_DEPTH)+1 bits and wrap naturally. Count = wptr - rptr.
- ERR set and W1C clear in the same cycle: set wins.
- ARESET asserted mid-transaction: any pending BVALID/RVALID drops next edge. FIFO contents and errors are discarded. The master must restart.
- IRQ = |ERR, registered, one cycle after the error edge.

Optional Feature:
AXIL_ADDN_SLVERR_EN.
- Defined: a push to a full channel returns BRESP = 10 (SLVERR), and a pop from an empty channel returns RRESP = 10. ERR bits are still set.
- Undefined: all responses are OKAY (00) and errors appear only in ERR and IRQ.

Test Plan:
1. Reset, then read 0x00, 0x04, 0x08 -> 0x00000001, 0x0000000F (NUM_CH=4, all empty), 0x00000000; IRQ=0.
2. Write 1,2,3,4 to 0x10 (INC=1), then read 0x10 four times -> 2,3,4,5 in order, all OKAY; then STATUS bit0=1.
3. Write INC=0xFFFFFFFF, push 0x00000005 to ch2 (0x18), pop -> 0x00000004 (wrap). Write INC with WSTRB=0001 data 0x10 -> INC reads 0xFFFFFF10.
4. Push 9 values to ch1 (depth 8) -> STATUS bit9=1, ERR bit1=1, IRQ=1; first 8 values pop correctly. Write 0x2 to 0x08 -> ERR=0, IRQ falls.
5. Pop empty ch3 -> RDATA=0, ERR bit11=1. With AXIL_ADDN_SLVERR_EN: RRESP=10, and the 9th push in test 4 returns BRESP=10.
6. Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID stay high with stable data, no second accept. Assert ARESET while BVALID=1 -> BVALID=0 and STATUS=0x0000000F after reset.
